router_out_alloc: RTL and testbench

Wormhole output-port allocator for the 5-port mesh router (L, N, E, W, S). It shares one output link among the five input ports. Once a packet's head flit wins, the block locks the link to that input until the tail flit has passed. Flow control toward the downstream router is credit-based, and the block drives the crossbar select for its output column.

---
 rtl/router_pkg.sv | 40 ++++
 rtl/rr_pick.sv | 42 ++++
 rtl/router_out_alloc.sv | 120 ++++++++++++
 tb/tb_router_out_alloc.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the 5-port mesh router (L, N, E, W, S).
//   NPORT              : number of router ports.
//   P_L .. P_S         : port index constants. These index the request, grant
//                        and select vectors.
//   alloc_state_t      : output-allocator FSM states.
//   onehot5(idx)       : 3-bit port index to 5-bit one-hot vector.
//                        Indices above 4 map to zero.
// -----------------------------------------------------------------------------
package router_pkg;

  localparam int NPORT = 5;

  localparam logic [2:0] P_L = 3'd0;
  localparam logic [2:0] P_N = 3'd1;
  localparam logic [2:0] P_E = 3'd2;
  localparam logic [2:0] P_W = 3'd3;
  localparam logic [2:0] P_S = 3'd4;

  typedef enum logic {
    ALLOC_IDLE = 1'b0,
    ALLOC_BUSY = 1'b1
  } alloc_state_t;

  function automatic logic [NPORT-1:0] onehot5(input logic [2:0] idx);
    logic [NPORT-1:0] v;
    v = '0;
    case (idx)
      P_L:     v = 5'b00001;
      P_N:     v = 5'b00010;
      P_E:     v = 5'b00100;
      P_W:     v = 5'b01000;
      P_S:     v = 5'b10000;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker over the five router ports.
// The scan starts at i_ptr and walks upward, wrapping from 4 back to 0.
// The first requesting index found is returned.
//   i_req   [4:0] : request vector
//   i_ptr   [2:0] : scan start index (0..4)
//   o_idx   [2:0] : chosen index; 0 when nothing is requested
//   o_found       : at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick
  import router_pkg::*;
(
  input  logic [NPORT-1:0] i_req,
  input  logic [2:0]       i_ptr,
  output logic [2:0]       o_idx,
  output logic             o_found
);

  function automatic logic [2:0] wrap5(input logic [3:0] v);
    return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
  endfunction

  // NOTE: every output of a combinational block gets a default before any
  // branch. Otherwise paths that never assign it infer a latch.
  always_comb begin
    logic [2:0] w_cand;
    o_idx   = '0;
    o_found = 1'b0;
    w_cand  = '0;
    // The scan runs from the farthest offset down to offset 0. The last hit
    // assigned is therefore the one closest to i_ptr, which is the winner.
    for (int k = NPORT - 1; k >= 0; k--) begin
      w_cand = wrap5({1'b0, i_ptr} + 4'(k));
      if (i_req[w_cand]) begin
        o_idx   = w_cand;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_out_alloc.sv
// -----------------------------------------------------------------------------
// router_out_alloc
// Wormhole output-port allocator for one output link of the 5-port router.
// A packet's head flit wins round-robin arbitration. The link then stays
// locked to that input until its tail flit transfers. Downstream flow control
// is credit-based.
//   clk            : clock, rising edge
//   rst            : synchronous, active-high reset
//   i_req    [4:0] : per-input flit valid toward this output (0=L .. 4=S)
//   i_tail   [4:0] : per-input tail marker, qualified by i_req
//   i_credit_in    : one-cycle pulse; downstream freed one buffer slot
//   o_grant  [4:0] : one-hot or zero; that input's flit moves this cycle
//   o_xbar_sel[4:0]: one-hot crossbar select for the owner; zero when idle
//   o_out_valid    : a flit is on the output link this cycle
//   o_busy         : link locked to an owner
//   o_credit_cnt   : credits currently available downstream
//   o_credit_err   : sticky; a credit arrived while the counter was full
// -----------------------------------------------------------------------------
module router_out_alloc
  import router_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] i_req,
  input  logic [NPORT-1:0] i_tail,
  input  logic             i_credit_in,
  output logic [NPORT-1:0] o_grant,
  output logic [NPORT-1:0] o_xbar_sel,
  output logic             o_out_valid,
  output logic             o_busy,
  output logic [CW-1:0]    o_credit_cnt,
  output logic             o_credit_err
);

  alloc_state_t  r_state;
  alloc_state_t  w_state_nxt;
  logic [2:0]    r_owner;
  logic [2:0]    r_ptr;
  logic [CW-1:0] r_credit_cnt;
  logic          r_credit_err;

  logic [2:0]    w_pick_idx;
  logic          w_pick_found;
  logic          w_xfer;       // owner's flit moves this cycle
  logic          w_tail_xfer;  // that flit is the packet's tail

  rr_pick u_rr_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  assign w_xfer      = (r_state == ALLOC_BUSY) && i_req[r_owner] && (r_credit_cnt != '0);
  assign w_tail_xfer = w_xfer && i_tail[r_owner];

  // State register.
  // NOTE: sequential state uses non-blocking assignments. All registers then
  // update together at the edge, whatever order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ALLOC_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ALLOC_IDLE: if (w_pick_found) w_state_nxt = ALLOC_BUSY;
      ALLOC_BUSY: if (w_tail_xfer)  w_state_nxt = ALLOC_IDLE;
      default:                      w_state_nxt = ALLOC_IDLE;
    endcase
  end

  // Output logic. The only input-to-output path is i_req[owner], through w_xfer.
  always_comb begin
    o_busy      = (r_state == ALLOC_BUSY);
    o_xbar_sel  = o_busy ? onehot5(r_owner) : '0;
    o_grant     = w_xfer ? onehot5(r_owner) : '0;
    o_out_valid = w_xfer;
  end

  // Owner and round-robin pointer. The credit count does not gate the pick.
  // The pointer moves only when a packet completes, to the port after the
  // finishing owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= P_L;
      r_ptr   <= P_L;
    end else begin
      if (r_state == ALLOC_IDLE && w_pick_found) r_owner <= w_pick_idx;
      if (w_tail_xfer) r_ptr <= (r_owner == P_S) ? P_L : r_owner + 3'd1;
    end
  end

  // Credit counter. A transfer and a returned credit in the same cycle cancel
  // out. A credit arriving at a full counter (with no transfer) is flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit_cnt <= CW'(CREDITS);
      r_credit_err <= 1'b0;
    end else begin
      case ({w_xfer, i_credit_in})
        2'b10: r_credit_cnt <= r_credit_cnt - 1'b1;
        2'b01: begin
          if (r_credit_cnt == CW'(CREDITS)) r_credit_err <= 1'b1;
          else                              r_credit_cnt <= r_credit_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_credit_cnt = r_credit_cnt;
  assign o_credit_err = r_credit_err;

endmodule

// File: tb/tb_router_out_alloc.sv
// -----------------------------------------------------------------------------
// tb_router_out_alloc
// Directed self-checking bench for router_out_alloc (CREDITS = 4).
// Each step drives the inputs for one cycle and pushes the outputs expected
// in that cycle onto a scoreboard. It then pops that entry mid-cycle and
// compares it with the outputs.
// -----------------------------------------------------------------------------
module tb_router_out_alloc;
  import router_pkg::*;

  localparam int CREDITS = 4;
  localparam int CW      = $clog2(CREDITS + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [NPORT-1:0] req;
  logic [NPORT-1:0] tail;
  logic             credit_in;
  logic [NPORT-1:0] grant;
  logic [NPORT-1:0] xbar_sel;
  logic             out_valid;
  logic             busy;
  logic [CW-1:0]    credit_cnt;
  logic             credit_err;

  typedef struct {
    logic [NPORT-1:0] grant;
    logic [NPORT-1:0] xsel;
    logic             busy;
    logic [CW-1:0]    cnt;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   step  = 0;

  router_out_alloc #(.CREDITS(CREDITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req        (req),
    .i_tail       (tail),
    .i_credit_in  (credit_in),
    .o_grant      (grant),
    .o_xbar_sel   (xbar_sel),
    .o_out_valid  (out_valid),
    .o_busy       (busy),
    .o_credit_cnt (credit_cnt),
    .o_credit_err (credit_err)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL step%0d %s: observed=%h expected=%h", step, tag, obs, exp);
    end
  endtask

  // One cycle: drive the inputs and record the expected outputs. Then check
  // the outputs mid-cycle, well before the next rising edge.
  task automatic cyc(input logic [4:0] r, input logic [4:0] t, input logic ci,
                     input logic [4:0] e_grant, input logic [4:0] e_xsel,
                     input logic e_busy, input int e_cnt, input logic e_err);
    exp_t e;
    @(negedge clk);
    step++;
    req       = r;
    tail      = t;
    credit_in = ci;
    e.grant = e_grant;
    e.xsel  = e_xsel;
    e.busy  = e_busy;
    e.cnt   = CW'(e_cnt);
    e.err   = e_err;
    sb.push_back(e);
    #2;
    if (sb.size() == 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL step%0d scoreboard_empty", step);
    end else begin
      e = sb.pop_front();
      cmp("grant",      8'(grant),      8'(e.grant));
      cmp("xbar_sel",   8'(xbar_sel),   8'(e.xsel));
      cmp("out_valid",  8'(out_valid),  8'(|e.grant));
      cmp("busy",       8'(busy),       8'(e.busy));
      cmp("credit_cnt", 8'(credit_cnt), 8'(e.cnt));
      cmp("credit_err", 8'(credit_err), 8'(e.err));
    end
  endtask

  task automatic do_reset(input logic [4:0] r);
    @(negedge clk);
    rst       = 1'b1;
    req       = r;
    tail      = '0;
    credit_in = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; tail = '0; credit_in = 1'b0;
    do_reset(5'b00000);

    // Reset state.
    cyc(5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 4, 0);

    // N sends a 3-flit packet while S waits; N wins from ptr 0.
    cyc(5'b10010, 5'b00000, 0, 5'b00000, 5'b00000, 0, 4, 0); // arbitration
    cyc(5'b10010, 5'b00000, 0, 5'b00010, 5'b00010, 1, 4, 0);
    cyc(5'b10010, 5'b00000, 0, 5'b00010, 5'b00010, 1, 3, 0);
    cyc(5'b10010, 5'b00010, 0, 5'b00010, 5'b00010, 1, 2, 0); // tail
    cyc(5'b10010, 5'b00000, 0, 5'b00000, 5'b00000, 0, 1, 0); // bubble; ptr=2, S wins
    cyc(5'b10010, 5'b10000, 0, 5'b10000, 5'b10000, 1, 1, 0); // S single flit

    // Refill the credits, then overflow the counter while idle.
    cyc(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, 0);
    cyc(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 1, 0);
    cyc(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 2, 0);
    cyc(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 3, 0);
    cyc(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 4, 0); // overflow
    cyc(5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 4, 1); // saturated, sticky

    // E sends 6 flits with no credits returned: 4 grants, then a stall.
    cyc(5'b00100, 5'b00000, 0, 5'b00000, 5'b00000, 0, 4, 1);
    cyc(5'b00100, 5'b00000, 0, 5'b00100, 5'b00100, 1, 4, 1);
    cyc(5'b00100, 5'b00000, 0, 5'b00100, 5'b00100, 1, 3, 1);
    cyc(5'b00100, 5'b00000, 0, 5'b00100, 5'b00100, 1, 2, 1);
    cyc(5'b00100, 5'b00000, 0, 5'b00100, 5'b00100, 1, 1, 1);
    cyc(5'b00100, 5'b00000, 0, 5'b00000, 5'b00100, 1, 0, 1); // stall
    cyc(5'b00100, 5'b00000, 1, 5'b00000, 5'b00100, 1, 0, 1); // credit back
    cyc(5'b00100, 5'b00000, 0, 5'b00100, 5'b00100, 1, 1, 1); // exactly one grant
    cyc(5'b00100, 5'b00000, 0, 5'b00000, 5'b00100, 1, 0, 1); // stall again
    cyc(5'b00100, 5'b00000, 1, 5'b00000, 5'b00100, 1, 0, 1);
    // Owner drops req while W requests: the lock holds and nothing is granted.
    cyc(5'b01000, 5'b00000, 0, 5'b00000, 5'b00100, 1, 1, 1);
    // Tail grant together with a returned credit: the count is unchanged.
    cyc(5'b00100, 5'b00100, 1, 5'b00100, 5'b00100, 1, 1, 1);
    cyc(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 1, 1);
    cyc(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 2, 1);
    cyc(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 3, 1);
    cyc(5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 4, 1);

    // Reset clears the sticky error and the pointer. All five ports then send
    // single-flit packets. Each grant returns a credit, so the count stays at 4.
    do_reset(5'b00000);
    for (int i = 0; i < 12; i++) begin
      logic [4:0] g;
      g = (i % 2 == 1) ? (5'b00001 << ((i / 2) % 5)) : 5'b00000;
      cyc(5'b11111, 5'b11111, (i % 2 == 1), g, g, (i % 2 == 1), 4, 0);
    end

    // W owns the link mid-packet when reset arrives; afterwards L wins.
    cyc(5'b01000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 4, 0);
    cyc(5'b01000, 5'b00000, 0, 5'b01000, 5'b01000, 1, 4, 0);
    cyc(5'b01000, 5'b00000, 0, 5'b01000, 5'b01000, 1, 3, 0);
    do_reset(5'b01000);
    cyc(5'b11111, 5'b00000, 0, 5'b00000, 5'b00000, 0, 4, 0);
    cyc(5'b11111, 5'b00000, 0, 5'b00001, 5'b00001, 1, 4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
